// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: valid/ready command initiator that sequences one ALU operation at a time.
// Define ALU_DRV_FIFO_EN for a DEPTH-entry request FIFO; otherwise a single holding register is used.
module alu_cmd_driver #(
  parameter int INPUT = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [INPUT-1:0]   req_opa,
  input  logic [INPUT-1:0]   req_opb,
  input  logic               req_cin,
  input  logic [3:0]         req_cmd,
  input  logic               req_mode,
  input  logic [1:0]         req_opsel,
  output logic [INPUT-1:0]   opa,
  output logic [INPUT-1:0]   opb,
  output logic               cin,
  output logic               ce,
  output logic               mode,
  output logic [3:0]         cmd,
  output logic [1:0]         valid,
  input  logic [2*INPUT-1:0] alu_res,
  input  logic               alu_err,
  input  logic               alu_oflow,
  input  logic               alu_cout,
  input  logic               alu_g,
  input  logic               alu_l,
  input  logic               alu_e,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*INPUT-1:0] rsp_res,
  output logic [5:0]         rsp_flags
);

  typedef struct packed {
    logic [INPUT-1:0] opa;
    logic [INPUT-1:0] opb;
    logic             cin;
    logic [3:0]       cmd;
    logic             mode;
    logic [1:0]       opsel;
  } req_t;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPTURE, S_RESP} state_t;

  state_t     state, state_next;
  req_t       in_req, head;
  logic       push, pop, empty, capture, is_mul;
  logic [1:0] wait_cnt;

  assign in_req = '{opa: req_opa, opb: req_opb, cin: req_cin, cmd: req_cmd,
                    mode: req_mode, opsel: req_opsel};
  assign push   = req_valid & req_ready;

`ifdef ALU_DRV_FIFO_EN
  localparam int AW = $clog2(DEPTH);

  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + (AW+1)'(1);
    else if (!push && pop) count_next = count - (AW+1)'(1);
  end

  // NOTE: non-blocking (<=) for every sequential update so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      req_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_next;
      req_ready <= (count_next < (AW+1)'(DEPTH));
    end
  end

  // NOTE: storage array has no reset; occupancy guards every read, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_req;
  end

  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
`else
  req_t hold;
  logic full, full_next;
  logic unused_depth;

  // DEPTH has no effect with the single holding register.
  assign unused_depth = (DEPTH != 0);
  assign full_next    = push | (full & ~pop);

  // NOTE: non-blocking (<=) for every sequential update so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      full      <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      if (push) hold <= in_req;
      full      <= full_next;
      req_ready <= ~full_next;
    end
  end

  assign empty = ~full;
  assign head  = hold;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (!empty) state_next = S_ISSUE;
      S_ISSUE:   state_next = S_WAIT;
      S_WAIT:    if (wait_cnt == 2'd1) state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_RESP;
      S_RESP:    if (rsp_ready) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    capture   = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE:    pop       = ~empty;
      S_CAPTURE: capture   = 1'b1;
      S_RESP:    rsp_valid = 1'b1;
      default:   ;
    endcase
  end

  // Multiplies pass through one extra ALU stage, so they hold the inputs one cycle longer.
  assign is_mul = mode & ((cmd == 4'b1001) | (cmd == 4'b1010));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa       <= '0;
      opb       <= '0;
      cin       <= 1'b0;
      cmd       <= '0;
      mode      <= 1'b0;
      valid     <= '0;
      ce        <= 1'b0;
      wait_cnt  <= '0;
      rsp_res   <= '0;
      rsp_flags <= '0;
    end else begin
      if (pop) begin
        opa   <= head.opa;
        opb   <= head.opb;
        cin   <= head.cin;
        cmd   <= head.cmd;
        mode  <= head.mode;
        valid <= head.opsel;
        ce    <= 1'b1;
      end
      if (state == S_ISSUE)     wait_cnt <= is_mul ? 2'd2 : 2'd1;
      else if (state == S_WAIT) wait_cnt <= wait_cnt - 2'd1;
      if (capture) begin
        ce        <= 1'b0;
        rsp_res   <= alu_res;
        rsp_flags <= {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e};
      end
    end
  end

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Command initiator for the ALU datapath. Accepts operation requests over a valid/ready port, drives the ALU operand/command inputs with the timing the ALU requires, and captures the result and flags. Returns each result on a valid/ready response port in request order. Sits between a test or control master and the ALU, so upstream logic never tracks ALU pipeline latency.

## Interface
Parameters:
- INPUT, 8, operand width; ALU result width is 2*INPUT.
- DEPTH, 4, request FIFO entries when `ALU_DRV_FIFO_EN` is defined (power of two, ≥2).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  request accepted when REQ_VALID & REQ_READY at a CLK edge.
- REQ_OPA, REQ_OPB  in  INPUT  operands.
- REQ_CIN  in  1  carry in.
- REQ_CMD  in  4  ALU command.
- REQ_MODE  in  1  1 = arithmetic, 0 = logical.
- REQ_OPSEL  in  2  operand-valid code forwarded to ALU VALID.
- OPA, OPB  out  INPUT  to ALU.
- CIN, CE, MODE  out  1  to ALU.
- CMD  out  4  to ALU.
- VALID  out  2  to ALU.
- ALU_RES  in  2*INPUT  from ALU RES.
- ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E  in  1  from ALU.
- RSP_VALID  out  1  response held until taken.
- RSP_READY  in  1  response consumed on RSP_VALID & RSP_READY.
- RSP_RES  out  2*INPUT  captured result.
- RSP_FLAGS  out  6  {ERR, OFLOW, COUT, G, L, E}.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, RESP.
- IDLE:
  - Request storage non-empty: pop head, load ALU output registers, go to ISSUE.
  - Otherwise stay; CE=0.
- ISSUE:
  - CE=1; OPA/OPB/CIN/CMD/MODE/VALID held stable.
  - Load wait counter: 1 normally; 2 for multiply commands (MODE=1 with CMD=4'b1001 or 4'b1010, which add an internal ALU stage).
  - Go to WAIT.
- WAIT:
  - Decrement the counter; inputs stay stable with CE=1.
  - At zero, go to CAPTURE.
- CAPTURE:
  - Register ALU_RES and the six flags into RSP_RES/RSP_FLAGS.
  - Drop CE to 0; go to RESP.
- RESP:
  - RSP_VALID=1; RSP_RES/RSP_FLAGS frozen while RSP_READY=0.
  - On handshake, go to IDLE.
- One transaction in flight; responses strictly in request order.
- No checking of CMD/OPSEL legality. The ALU's ERR is passed through unchanged.
- Request storage:
  - Full: REQ_READY=0.
  - Empty: FSM stays in IDLE.
  - Push and pop in the same cycle: occupancy unchanged.
  - Full with a simultaneous pop: REQ_READY stays 0 that cycle. REQ_READY is registered from occupancy.

## Timing
- Reset (RST_N=0, asynchronous), all outputs and state cleared:
  - FSM=IDLE; storage empty.
  - REQ_READY=0 during reset, 1 from the first edge after release.
  - OPA=OPB=0; CIN=CE=MODE=0; CMD=0; VALID=0.
  - RSP_VALID=0; RSP_RES=0; RSP_FLAGS=0.
- Reset mid-transaction: in-flight and queued requests are discarded, no response is produced, CE drops to 0 immediately.
- Latency, accept edge to RSP_VALID high (storage empty, RSP_READY=1): 4 edges normal, 5 edges multiply.
- Throughput: one transaction per 5 cycles (6 for multiply) with RSP_READY held high.
- RSP backpressure stalls the FSM in RESP. Requests keep being accepted until storage is full.

## Configuration
- `ALU_DRV_FIFO_EN` defined: DEPTH-entry circular FIFO with wrapping read/write pointers and an occupancy counter.
- Undefined: single-entry holding register. REQ_READY=1 only when the register is empty; it is freed on the IDLE pop. Latency is identical, DEPTH is ignored.

## Test plan
- ADD, MODE=1, CMD=0000, OPSEL=11, OPA=200, OPB=100 -> RSP_RES=300, COUT=1, ERR=0. RSP_VALID exactly 4 edges after accept.
- Multiply, MODE=1, CMD=1001, OPA=3, OPB=4 -> RSP_RES=20. RSP_VALID 5 edges after accept; CE high for 4 consecutive cycles.
- Compare, MODE=1, CMD=1000, OPA=5, OPB=9 -> RSP_FLAGS=6'b000010 (L=1). Illegal MODE=0, CMD=1110 -> ERR flag=1, RSP_RES=0.
- Back-to-back DEPTH+2 requests with RSP_READY=0 -> REQ_READY drops after DEPTH+1 accepts (FIFO build). Release RSP_READY -> all responses in order, with no loss or duplication across pointer wrap.
- Assert RST_N low during WAIT -> CE=0 and RSP_VALID=0 immediately. After release, no stale response appears, and a fresh request completes normally.
- Hold RSP_READY=0 for 10 cycles in RESP -> RSP_RES/RSP_FLAGS stable and ALU inputs CE=0 throughout. Handshake then completes once.
